// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared constants and types for the M-extension divide unit.
//   XLEN            : datapath width (fixed at 32)
//   FUNCT3_*        : funct3 encodings of DIV/DIVU/REM/REMU
//   FUNCT7_MULDIV   : funct7 shared by all M-extension ops
//   DIV_CNT_W       : width of the divide step counter
//   div_state_t     : divide FSM state encoding {IDLE, BUSY, DONE}
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_CNT_W = 5;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_iter_step.sv
// div_iter_step -- one combinational restoring-division step.
//   rem_i     : current partial remainder (always < divisor_i)
//   quot_i    : dividend bits still to be consumed, MSB first; quotient
//               bits shift in at the LSB as dividend bits leave at the MSB
//   divisor_i : absolute divisor
//   rem_o     : next partial remainder
//   quot_o    : next dividend/quotient shift register
module div_iter_step
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_i, quot_i[XLEN-1]};
        diff    = shifted - {1'b0, divisor_i};
        // shifted < 2*divisor, so a non-negative difference never sets the
        // top bit; the top bit set means the subtraction borrowed.
        if (!diff[XLEN]) begin
            rem_o  = diff[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o  = shifted[XLEN-1:0];
            quot_o = {quot_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_div_unit.sv
// muldiv_div_unit -- iterative 32-bit DIV/DIVU/REM/REMU unit for the EX stage.
// Optional feature: define MYRV_DIV_BYPASS_EN to add a last-result cache that
// completes a repeated divide (same a, b, signedness) in one cycle.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   EX_div_req  : EX holds a divide/remainder instruction
//   EX_funct3   : 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   EX_op_a/b   : dividend / divisor
//   EX_kill     : abort the in-flight divide
//   div_stall   : hold the front of the pipeline while the divide runs
//   div_done    : one-cycle pulse, div_result valid
//   div_result  : quotient or remainder, zero whenever div_done is low
//   dbg_state   : current FSM state
//
// Handshake: a request is held on EX_div_req with stable operands while
// div_stall is high; the cycle div_done pulses is the cycle the instruction
// may leave EX. Dropping EX_div_req or raising EX_kill abandons the divide.
module muldiv_div_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            EX_div_req,
    input  logic [2:0]      EX_funct3,
    input  logic [XLEN-1:0] EX_op_a,
    input  logic [XLEN-1:0] EX_op_b,
    input  logic            EX_kill,
    output logic            div_stall,
    output logic            div_done,
    output logic [XLEN-1:0] div_result,
    output div_state_t      dbg_state
);

    div_state_t           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      dvs_q, dvs_d;
    logic [XLEN-1:0]      rem_q, rem_d;
    logic [XLEN-1:0]      quot_q, quot_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic                 rem_sel_q, rem_sel_d;

    logic [XLEN-1:0]      step_rem, step_quot;
    logic [XLEN-1:0]      quot_fix, rem_fix;
    logic [XLEN-1:0]      a_abs, b_abs;
    logic                 req_signed, start, div_by_zero, overflow;

`ifdef MYRV_DIV_BYPASS_EN
    logic            c_valid_q, c_valid_d;
    logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d;
    logic            c_signed_q, c_signed_d;
    logic [XLEN-1:0] c_quot_q, c_quot_d, c_rem_q, c_rem_d;
    logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic            signed_q, signed_d;
    logic            cache_hit;

    assign cache_hit = c_valid_q && (c_a_q == EX_op_a) && (c_b_q == EX_op_b)
                       && (c_signed_q == req_signed);
`endif

    div_iter_step u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // funct3[0]=0 selects the signed forms, funct3[1]=1 selects remainder.
    assign req_signed  = ~EX_funct3[0];
    assign start       = EX_div_req & EX_funct3[2] & ~EX_kill;
    assign a_abs       = (req_signed && EX_op_a[XLEN-1]) ? -EX_op_a : EX_op_a;
    assign b_abs       = (req_signed && EX_op_b[XLEN-1]) ? -EX_op_b : EX_op_b;
    assign div_by_zero = (EX_op_b == '0);
    assign overflow    = req_signed && (EX_op_a == {1'b1, {(XLEN-1){1'b0}}})
                         && (EX_op_b == '1);

    assign quot_fix   = q_neg_q ? -quot_q : quot_q;
    assign rem_fix    = r_neg_q ? -rem_q : rem_q;
    assign div_done   = (state_q == DONE);
    assign div_result = div_done ? (rem_sel_q ? rem_fix : quot_fix) : '0;
    // Reset forces the stall low even if the pipeline still presents a request.
    assign div_stall  = EX_div_req & ~div_done & ~EX_kill & rst_n;
    assign dbg_state  = state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        rem_sel_d = rem_sel_q;
`ifdef MYRV_DIV_BYPASS_EN
        c_valid_d  = c_valid_q;
        c_a_d      = c_a_q;
        c_b_d      = c_b_q;
        c_signed_d = c_signed_q;
        c_quot_d   = c_quot_q;
        c_rem_d    = c_rem_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        signed_d   = signed_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_sel_d = EX_funct3[1];
`ifdef MYRV_DIV_BYPASS_EN
                    op_a_d   = EX_op_a;
                    op_b_d   = EX_op_b;
                    signed_d = req_signed;
`endif
                    // Special cases load final, already-correct values.
                    if (div_by_zero) begin
                        quot_d  = '1;
                        rem_d   = EX_op_a;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = DONE;
                    end else if (overflow) begin
                        quot_d  = {1'b1, {(XLEN-1){1'b0}}};
                        rem_d   = '0;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = DONE;
`ifdef MYRV_DIV_BYPASS_EN
                    end else if (cache_hit) begin
                        quot_d  = c_quot_q;
                        rem_d   = c_rem_q;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = DONE;
`endif
                    end else begin
                        rem_d   = '0;
                        quot_d  = a_abs;
                        dvs_d   = b_abs;
                        q_neg_d = req_signed & (EX_op_a[XLEN-1] ^ EX_op_b[XLEN-1]);
                        r_neg_d = req_signed & EX_op_a[XLEN-1];
                        cnt_d   = DIV_CNT_W'(XLEN - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!EX_div_req) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef MYRV_DIV_BYPASS_EN
                c_valid_d  = 1'b1;
                c_a_d      = op_a_q;
                c_b_d      = op_b_q;
                c_signed_d = signed_q;
                c_quot_d   = quot_fix;
                c_rem_d    = rem_fix;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Kill overrides everything, including a DONE-cycle cache write.
        if (EX_kill) begin
            state_d = IDLE;
`ifdef MYRV_DIV_BYPASS_EN
            c_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            rem_sel_q <= rem_sel_d;
        end
    end

`ifdef MYRV_DIV_BYPASS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid_q  <= 1'b0;
            c_a_q      <= '0;
            c_b_q      <= '0;
            c_signed_q <= 1'b0;
            c_quot_q   <= '0;
            c_rem_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            signed_q   <= 1'b0;
        end else begin
            c_valid_q  <= c_valid_d;
            c_a_q      <= c_a_d;
            c_b_q      <= c_b_d;
            c_signed_q <= c_signed_d;
            c_quot_q   <= c_quot_d;
            c_rem_q    <= c_rem_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            signed_q   <= signed_d;
        end
    end
`endif

endmodule

// File: tb/tb_muldiv_div_unit.sv
// tb_muldiv_div_unit -- bench for muldiv_div_unit (honours MYRV_DIV_BYPASS_EN).
module tb_muldiv_div_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        EX_div_req;
    logic [2:0]  EX_funct3;
    logic [31:0] EX_op_a;
    logic [31:0] EX_op_b;
    logic        EX_kill;
    logic        div_stall;
    logic        div_done;
    logic [31:0] div_result;
    div_state_t  dbg_state;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q[$];

`ifdef MYRV_DIV_BYPASS_EN
    bit          m_valid = 1'b0;
    logic [31:0] m_a, m_b;
    bit          m_sgn;
`endif

    muldiv_div_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .EX_div_req (EX_div_req),
        .EX_funct3  (EX_funct3),
        .EX_op_a    (EX_op_a),
        .EX_op_b    (EX_op_b),
        .EX_kill    (EX_kill),
        .div_stall  (div_stall),
        .div_done   (div_done),
        .div_result (div_result),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cache_forget();
`ifdef MYRV_DIV_BYPASS_EN
        m_valid = 1'b0;
`endif
    endtask

    // Reference: plain integer arithmetic with the RISC-V special-case rules.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) begin
            qv = 64'hFFFF_FFFF;
            rv = {32'd0, a};
        end else if (!f3[0]) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;   // truncates toward zero; overflow wraps to 0x80000000
            r  = sa % sb;   // sign follows the dividend
            qv = q;
            rv = r;
        end else begin
            qv = {32'd0, a / b};
            rv = {32'd0, a % b};
        end
        return f3[1] ? rv[31:0] : qv[31:0];
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (div_done === 1'b1) begin
                if (exp_q.size() == 0) check("unexpected_done", div_done, 1'b0);
                else check("result", div_result, exp_q.pop_front());
            end else if (div_result !== 32'd0) begin
                check("result_zero_when_idle", div_result, 32'd0);
            end
        end
    end

    // driver: one full divide, request held until div_done
    task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int  lat, done_at;
        bit  special, stall_ok;
        bit  sgn;
        sgn     = ~f3[0];
        special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        lat     = special ? 1 : 33;
`ifdef MYRV_DIV_BYPASS_EN
        if (m_valid && m_a == a && m_b == b && m_sgn == sgn) lat = 1;
`endif
        @(negedge clk);
        EX_div_req = 1'b1;
        EX_funct3  = f3;
        EX_op_a    = a;
        EX_op_b    = b;
        exp_q.push_back(ref_div(f3, a, b));
        #1 check("stall_cycle0", div_stall, 1'b1);
        done_at  = 0;
        stall_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (div_done === 1'b1) begin
                done_at = n;
                break;
            end
            if (div_stall !== 1'b1) stall_ok = 1'b0;
        end
        if (done_at == 0) begin
            check("done_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_back());
        end else begin
            check("latency", done_at, lat);
            check("stall_held", stall_ok, 1'b1);
            check("stall_low_at_done", div_stall, 1'b0);
        end
        EX_div_req = 1'b0;
`ifdef MYRV_DIV_BYPASS_EN
        m_valid = 1'b1;
        m_a     = a;
        m_b     = b;
        m_sgn   = sgn;
`endif
    endtask

    // start a divide and abort it after abort_cyc cycles (kill or request drop)
    task automatic run_abort(input int abort_cyc, input bit use_kill);
        @(negedge clk);
        EX_div_req = 1'b1;
        EX_funct3  = FUNCT3_DIVU;
        EX_op_a    = 32'd1000;
        EX_op_b    = 32'd3;
        for (int n = 1; n <= abort_cyc; n++) @(negedge clk);
        check("busy_before_abort", dbg_state, BUSY);
        if (use_kill) begin
            EX_kill = 1'b1;
            #1 check("stall_low_on_kill", div_stall, 1'b0);
            cache_forget();
        end else begin
            EX_div_req = 1'b0;
        end
        @(negedge clk);
        check("idle_after_abort", dbg_state, IDLE);
        EX_kill    = 1'b0;
        EX_div_req = 1'b0;
        repeat (40) @(negedge clk);   // monitor flags any stray done
    endtask

    logic [31:0] ra, rb, pa, pb;

    initial begin
        rst_n = 1'b0; EX_div_req = 1'b0; EX_funct3 = FUNCT3_DIV;
        EX_op_a = '0; EX_op_b = '0; EX_kill = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", dbg_state, IDLE);
        check("rst_done", div_done, 1'b0);
        check("rst_result", div_result, 32'd0);
        check("rst_stall", div_stall, 1'b0);
        rst_n = 1'b1;

        // directed cases
        run_div(FUNCT3_DIVU, 32'd100, 32'd7);
        run_div(FUNCT3_REMU, 32'd100, 32'd7);
        run_div(FUNCT3_DIV,  32'hFFFF_FFF9, 32'd2);
        run_div(FUNCT3_REM,  32'hFFFF_FFF9, 32'd2);
        run_div(FUNCT3_REM,  32'd7, 32'hFFFF_FFFE);
        run_div(FUNCT3_DIVU, 32'd5, 32'd0);
        run_div(FUNCT3_REMU, 32'd5, 32'd0);
        run_div(FUNCT3_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run_div(FUNCT3_REM,  32'h8000_0000, 32'hFFFF_FFFF);
        run_div(FUNCT3_DIV,  32'd100, 32'd7);
        run_div(FUNCT3_REM,  32'd100, 32'd7);

        // kill in cycle 10, then request drop in BUSY
        run_abort(10, 1'b1);
        run_abort(8, 1'b0);
        run_div(FUNCT3_DIVU, 32'd1000, 32'd3);

        // reset asserted in cycle 5 of a divide
        @(negedge clk);
        EX_div_req = 1'b1; EX_funct3 = FUNCT3_DIV; EX_op_a = 32'd999; EX_op_b = 32'd4;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_stall", div_stall, 1'b0);
        check("midrst_done", div_done, 1'b0);
        check("midrst_result", div_result, 32'd0);
        check("midrst_state", dbg_state, IDLE);
        EX_div_req = 1'b0;
        cache_forget();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_div(FUNCT3_DIV, 32'd999, 32'd4);

        // randomized
        pa = 32'd12345; pb = 32'd67;
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'hFFFF_FFFF;
                3: begin ra = pa; rb = pb; end
                4: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom >> $urandom_range(0, 28);
            endcase
            run_div(3'b100 | 3'($urandom_range(0, 3)), ra, rb);
            pa = ra; pb = rb;
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_div_unit.md
MULDIV_DIV_UNIT -- requirements
Module: muldiv_div_unit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 via the package constant XLEN.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 EX_div_req  input  1  the EX instruction is DIV/DIVU/REM/REMU (OpcodeOp, funct7=0000001, funct3[2]=1).
REQ-005 EX_funct3  input  3  selects the operation: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 EX_op_a  input  32  dividend (post-forwarding rs1 value).
REQ-007 EX_op_b  input  32  divisor (post-forwarding rs2 value).
REQ-008 EX_kill  input  1  aborts any in-flight divide.
REQ-009 div_stall  output  1  stall request to the pipeline controller; holds IF/ID and ID/EX and keeps the instruction in EX.
REQ-010 div_done  output  1  one-cycle pulse; div_result is valid in this cycle.
REQ-011 div_result  output  32  quotient or remainder, as selected by EX_funct3.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-013 div_stall SHALL be combinational and equal EX_div_req & ~div_done & ~EX_kill.
REQ-014 IDLE with EX_div_req=1 and EX_kill=0: latch the absolute operand values, the sign flags and EX_funct3; load the 5-bit counter with 31; go to BUSY.
REQ-015 Divide-by-zero detected in IDLE: go directly to DONE with quotient 0xFFFFFFFF and remainder = EX_op_a.
REQ-016 Signed overflow detected in IDLE (DIV/REM, a=0x80000000, b=0xFFFFFFFF): go directly to DONE with quotient 0x80000000 and remainder 0.
REQ-017 BUSY: perform one restoring-division step per cycle on the absolute values; decrement the counter; go to DONE after the step taken at count 0.
REQ-018 Normal latency: with the request in cycle 0, div_done SHALL assert in cycle 33 and div_stall SHALL be high in cycles 0..32. Special cases complete with div_done in cycle 1.
REQ-019 DONE: assert div_done, drive the sign-corrected result, and return to IDLE the next cycle.
REQ-020 Sign correction: quotient is negated when the signs differ (signed ops only); the remainder takes the dividend's sign.
REQ-021 A back-to-back divide, with a new request in the cycle after DONE, SHALL start from IDLE normally.
REQ-022 EX_kill in any state SHALL force IDLE on the next edge; div_done SHALL NOT assert for the killed operation.
REQ-023 EX_div_req dropping in BUSY SHALL abort the operation to IDLE, the same as EX_kill.
REQ-024 div_result SHALL be 0 whenever div_done=0.

Reset
REQ-025 Asynchronous reset SHALL set state=IDLE, the counter to 0, all operand, partial-remainder and quotient registers to 0, and the bypass valid flag to 0.
REQ-026 During reset, div_stall=0, div_done=0 and div_result=0.
REQ-027 Reset asserted mid-BUSY SHALL discard the operation; the first request after reset release behaves as a fresh start.

Configuration
REQ-028 Macro MYRV_DIV_BYPASS_EN SHALL, when defined, add a last-result cache holding a, b, signedness, quotient, remainder and a valid flag.
REQ-029 With the macro defined, a request in IDLE whose a, b and signedness match a valid cache entry SHALL go to DONE in cycle 1 and return the requested quotient or remainder.
REQ-030 The cache SHALL be written at every DONE; it SHALL be invalidated by reset and by EX_kill.
REQ-031 Without the macro, no cache logic SHALL exist and every non-special request SHALL take 33 cycles.

Structure
REQ-032 riscv_pkg SHALL hold XLEN, the funct3 constants FUNCT3_DIV/DIVU/REM/REMU, FUNCT7_MULDIV, and the typedef enum div_state_t {IDLE, BUSY, DONE}.
REQ-033 One combinational sub-module, div_iter_step, SHALL implement a single shift/compare/subtract step.

Verification
REQ-034 DIVU 100/7, request held: stall high cycles 0-32; div_done in cycle 33 with result 14; REMU with the same operands gives 2.
REQ-035 DIV 0xFFFFFFF9/2 gives 0xFFFFFFFD; REM with the same operands gives 0xFFFFFFFF; REM 7/0xFFFFFFFE gives 1.
REQ-036 DIVU 5/0 gives 0xFFFFFFFF in cycle 1; REMU 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM with the same operands gives 0.
REQ-037 EX_kill in cycle 10 gives state IDLE in cycle 11 and no div_done; rst_n low in cycle 5 clears all outputs immediately; the next request completes after 33 cycles.
REQ-038 DIV 100/7 then REM 100/7 back-to-back: the second done is in cycle 1 with MYRV_DIV_BYPASS_EN (result 2) and in cycle 33 without it.
